sequencer: RTL and testbench

SEQUENCER -- requirements
Module: sequencer

---
 rtl/sequencer.sv | 151 +++++++++++++++
 tb/tb_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequencer.sv
// Command sequencer between a from-PC and a to-PC FIFO: executes register
// access, echo, wait and count commands and streams responses with valid/ready.
`timescale 1ns/1ps

module sequencer #(
    parameter int NREGS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] fpc_data,
    input  logic        fpc_valid,
    output logic        fpc_read,
    input  logic        tpc_ready,
    output logic        tpc_write,
    output logic [63:0] tpc_data
);

    localparam int            IW      = $clog2(NREGS);
    localparam logic [IW-1:0] ERR_IDX = IW'(NREGS - 1);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_WAIT  = 4'h3;
    localparam logic [3:0] OP_ECHO  = 4'h4;
    localparam logic [3:0] OP_COUNT = 4'h5;

    typedef enum logic [1:0] {IDLE, WAIT, EMIT, COUNT} state_t;

    state_t state, state_next, exec_state;

    logic [3:0]    op;
    logic [27:0]   addr;
    logic [31:0]   data;
    logic [IW-1:0] idx;

    logic [31:0] regs [NREGS];
    logic [31:0] err_cnt;
    logic [31:0] wait_cnt;
    logic [31:0] rd_data;
    logic [15:0] cnt_i;
    logic [15:0] cnt_n;
    logic        count_last;

    assign op   = fpc_data[63:60];
    assign addr = fpc_data[59:32];
    assign data = fpc_data[31:0];
    assign idx  = fpc_data[32 +: IW];

    // The top register index is an alias for the error counter.
    assign rd_data    = (idx == ERR_IDX) ? err_cnt : regs[idx];
    assign count_last = (cnt_i == cnt_n - 16'd1);

    // A new command is accepted only while the output slot is free or draining this edge.
    always_comb begin
        fpc_read = 1'b0;
        if (reset && fpc_valid && (state == IDLE || state == EMIT))
            fpc_read = !tpc_write || tpc_ready;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        exec_state = IDLE;
        case (op)
            OP_NOP, OP_WRITE: exec_state = IDLE;
            OP_READ, OP_ECHO: exec_state = EMIT;
            OP_WAIT:          exec_state = (data != 32'd0) ? WAIT : IDLE;
            OP_COUNT:         exec_state = (data[15:0] != 16'd0) ? COUNT : IDLE;
            default:          exec_state = IDLE;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fpc_read) state_next = exec_state;
            EMIT: begin
                if (fpc_read)       state_next = exec_state;
                else if (tpc_ready) state_next = IDLE;
            end
            WAIT:  if (wait_cnt == 32'd1) state_next = IDLE;
            COUNT: if (tpc_ready && count_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the register file is reset explicitly because its cleared contents are architecturally visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tpc_write <= 1'b0;
            tpc_data  <= '0;
            err_cnt   <= '0;
            wait_cnt  <= '0;
            cnt_i     <= '0;
            cnt_n     <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                EMIT: if (tpc_ready) tpc_write <= 1'b0;
                WAIT: wait_cnt <= wait_cnt - 32'd1;
                COUNT: begin
                    if (tpc_ready) begin
                        if (count_last) begin
                            tpc_write <= 1'b0;
                        end else begin
                            cnt_i          <= cnt_i + 16'd1;
                            tpc_data[15:0] <= cnt_i + 16'd1;
                        end
                    end
                end
                default: ;
            endcase

            // A popped command overrides the EMIT drain above when both happen on one edge.
            if (fpc_read) begin
                case (op)
                    OP_NOP: ;
                    OP_WRITE: begin
                        if (idx == ERR_IDX) err_cnt   <= '0;
                        else                regs[idx] <= data;
                    end
                    OP_READ: begin
                        tpc_write <= 1'b1;
                        tpc_data  <= {OP_READ, addr, rd_data};
                    end
                    OP_ECHO: begin
                        tpc_write <= 1'b1;
                        tpc_data  <= fpc_data;
                    end
                    OP_WAIT: wait_cnt <= data;
                    OP_COUNT: begin
                        if (data[15:0] != 16'd0) begin
                            tpc_write <= 1'b1;
                            tpc_data  <= {addr, OP_COUNT, 16'h0, 16'h0};
                            cnt_i     <= '0;
                            cnt_n     <= data[15:0];
                        end
                    end
                    default: if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequencer.sv
// Bench for sequencer: directed scenarios plus a random command stream, all
// responses compared against a transaction-level model of the command set.
`timescale 1ns/1ps

module tb_sequencer;

    localparam int NREGS = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] fpc_data;
    logic        fpc_valid;
    logic        fpc_read;
    logic        tpc_ready;
    logic        tpc_write;
    logic [63:0] tpc_data;

    sequencer #(.NREGS(NREGS)) dut (
        .clock     (clock),
        .reset     (reset),
        .fpc_data  (fpc_data),
        .fpc_valid (fpc_valid),
        .fpc_read  (fpc_read),
        .tpc_ready (tpc_ready),
        .tpc_write (tpc_write),
        .tpc_data  (tpc_data)
    );

    always #5 clock = ~clock;

    int total = 0, passed = 0, failed = 0;
    int cyc = 0, viol = 0, hold_viol = 0;

    logic [63:0] q[$];
    logic [63:0] got[$];
    logic [63:0] exp_q[$];
    int          got_cyc[$];
    int          pop_cyc[$];

    logic        s_twr = 1'b0, s_pop = 1'b0, prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    logic [31:0] m_regs [NREGS];
    logic [31:0] m_err;

    logic pat3 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [27:0] a, input logic [31:0] d);
        return {op, a, d};
    endfunction

    function automatic logic [63:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 64'hx;
    endfunction

    function automatic int pc(input int i);
        return (i < pop_cyc.size()) ? pop_cyc[i] : -1000;
    endfunction

    function automatic int gc(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_err = '0;
    endtask

    // Whole-command effect: register update and the full list of response words.
    task automatic model_exec(input logic [63:0] w);
        logic [27:0] a;
        int          idx;
        a   = w[59:32];
        idx = int'(a) % NREGS;
        case (w[63:60])
            4'h0: ;
            4'h1: if (idx == NREGS - 1) m_err = '0; else m_regs[idx] = w[31:0];
            4'h2: exp_q.push_back({4'h2, a, (idx == NREGS - 1) ? m_err : m_regs[idx]});
            4'h3: ;
            4'h4: exp_q.push_back(w);
            4'h5: for (int i = 0; i < int'(w[15:0]); i++) exp_q.push_back({a, 4'h5, 16'h0, 16'(i)});
            default: if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
        endcase
    endtask

    // One clock: drive at the falling edge, sample just after, log what the next rising edge will do.
    task automatic cycle(input logic rdy, input logic ven);
        logic [63:0] w;
        @(negedge clock);
        tpc_ready = rdy;
        fpc_valid = ven && (q.size() > 0);
        fpc_data  = fpc_valid ? q[0] : {$urandom, $urandom};
        #1;
        s_pop = fpc_read;
        s_twr = tpc_write;
        if (fpc_read && !fpc_valid) viol++;
        if (fpc_read && tpc_write && !tpc_ready) viol++;
        if (prev_stall && (!tpc_write || tpc_data !== prev_data)) hold_viol++;
        if (fpc_read && fpc_valid) begin
            w = q.pop_front();
            model_exec(w);
            pop_cyc.push_back(cyc);
        end
        if (tpc_write && tpc_ready) begin
            got.push_back(tpc_data);
            got_cyc.push_back(cyc);
        end
        prev_stall = tpc_write && !tpc_ready;
        prev_data  = tpc_data;
        cyc++;
    endtask

    task automatic drain(input logic rnd, input string tag);
        int n;
        n = 0;
        do begin
            if (rnd) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
            else     cycle(1'b1, 1'b1);
            n++;
        end while ((q.size() > 0 || s_twr || s_pop) && n < 5000);
        check({tag, "_drained"}, 64'(q.size() > 0 || s_twr || s_pop), 64'd0);
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_nwords"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), got_at(i), exp_q[i]);
    endtask

    task automatic clear_logs();
        got.delete();
        exp_q.delete();
        got_cyc.delete();
        pop_cyc.delete();
    endtask

    function automatic logic [63:0] rand_cmd();
        int          sel;
        logic [3:0]  op;
        logic [27:0] a;
        logic [31:0] d;
        sel = int'($urandom_range(0, 9));
        a   = 28'($urandom);
        d   = $urandom;
        case (sel)
            0:       op = 4'h0;
            1, 2:    op = 4'h1;
            3, 4, 9: op = 4'h2;
            5: begin op = 4'h3; d = 32'($urandom_range(0, 6)); end
            6:       op = 4'h4;
            7: begin op = 4'h5; d[15:0] = 16'($urandom_range(0, 4)); end
            default: op = 4'($urandom_range(6, 15));
        endcase
        return {op, a, d};
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] tmp;
        logic [27:0] err_addr;
        int          n;

        // Reset: outputs quiet even with a valid word presented.
        fpc_valid = 1'b1;
        fpc_data  = mk(4'h4, 28'h1, 32'h2);
        tpc_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        #1;
        check("rst_fpc_read", 64'(fpc_read), 64'd0);
        check("rst_tpc_write", 64'(tpc_write), 64'd0);
        check("rst_tpc_data", tpc_data, 64'd0);
        @(negedge clock);
        fpc_valid = 1'b0;
        reset     = 1'b1;

        // WRITE then READ of register 3, one-cycle response latency.
        q.push_back(mk(4'h1, 28'd3, 32'hDEAD_BEEF));
        q.push_back(mk(4'h2, 28'd3, $urandom));
        drain(1'b0, "t1");
        check("t1_read_word", got_at(0), 64'h2000_0003_DEAD_BEEF);
        check("t1_latency", 64'(gc(0) - pc(1)), 64'd1);
        compare_outputs("t1");
        clear_logs();

        // Four ECHO words back to back at full throughput.
        for (int k = 0; k < 4; k++) q.push_back(mk(4'h4, 28'($urandom), $urandom));
        drain(1'b0, "t2");
        check("t2_pop_span", 64'(pc(3) - pc(0)), 64'd3);
        check("t2_out_span", 64'(gc(3) - gc(0)), 64'd3);
        check("t2_latency", 64'(gc(0) - pc(0)), 64'd1);
        compare_outputs("t2");
        clear_logs();

        // COUNT addr 7, N = 3 under a toggling ready.
        q.push_back(mk(4'h5, 28'd7, {16'hBEEF, 16'd3}));
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) cycle(pat3[k], 1'b1);
        cycle(1'b1, 1'b1);
        check("t3_write_low_after", 64'(s_twr), 64'd0);
        for (int k = 0; k < 3; k++)
            check($sformatf("t3_count%0d", k), got_at(k), {28'd7, 4'h5, 16'h0, 16'(k)});
        check("t3_hold", 64'(hold_viol), 64'd0);
        compare_outputs("t3");
        clear_logs();

        // WAIT 5 holds off the next pop for exactly five cycles.
        q.push_back(mk(4'h3, 28'($urandom), 32'd5));
        q.push_back(mk(4'h4, 28'($urandom), $urandom));
        drain(1'b0, "t4a");
        check("t4_wait5_gap", 64'(pc(1) - pc(0)), 64'd6);
        compare_outputs("t4a");
        clear_logs();

        // WAIT 0 and COUNT 0 are single-cycle no-output commands.
        q.push_back(mk(4'h3, 28'($urandom), 32'd0));
        q.push_back(mk(4'h4, 28'($urandom), $urandom));
        q.push_back(mk(4'h5, 28'($urandom), {16'hFFFF, 16'd0}));
        q.push_back(mk(4'h4, 28'($urandom), $urandom));
        drain(1'b0, "t4b");
        check("t4_wait0_gap", 64'(pc(1) - pc(0)), 64'd1);
        check("t4_count0_gap", 64'(pc(3) - pc(2)), 64'd1);
        compare_outputs("t4b");
        clear_logs();

        // Unknown ops bump the error counter, visible at the top register index.
        err_addr = (28'($urandom) & ~28'(NREGS - 1)) | 28'(NREGS - 1);
        q.push_back(mk(4'h7, 28'($urandom), $urandom));
        q.push_back(mk(4'hF, 28'($urandom), $urandom));
        q.push_back(mk(4'h2, err_addr, $urandom));
        q.push_back(mk(4'h1, err_addr, $urandom));
        q.push_back(mk(4'h2, err_addr, $urandom));
        drain(1'b0, "t5");
        tmp = got_at(0);
        check("t5_err_count", 64'(tmp[31:0]), 64'd2);
        tmp = got_at(1);
        check("t5_err_cleared", 64'(tmp[31:0]), 64'd0);
        compare_outputs("t5");
        clear_logs();

        // Random command stream with random FIFO gaps and back-pressure.
        for (int k = 0; k < 300; k++) q.push_back(rand_cmd());
        drain(1'b1, "t6");
        compare_outputs("t6");
        clear_logs();

        // Reset in the middle of a long COUNT.
        q.push_back(mk(4'h1, 28'd0, 32'h1234_5678));
        q.push_back(mk(4'h5, 28'h0ABC_DEF, {16'h0, 16'd100}));
        n = 0;
        while (got.size() < 10 && n < 300) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        check("t7_ten_words", 64'(got.size()), 64'd10);
        for (int k = 0; k < 10; k++)
            check($sformatf("t7_pre_word%0d", k), got_at(k), exp_q[k]);
        @(posedge clock);
        #2;
        reset     = 1'b0;
        fpc_valid = 1'b1;
        fpc_data  = mk(4'h4, 28'h5, 32'h6);
        #1;
        check("t7_rst_tpc_write", 64'(tpc_write), 64'd0);
        check("t7_rst_tpc_data", tpc_data, 64'd0);
        check("t7_rst_fpc_read", 64'(fpc_read), 64'd0);
        repeat (2) @(negedge clock);
        clear_logs();
        model_reset();
        q.delete();
        prev_stall = 1'b0;
        fpc_valid  = 1'b0;
        reset      = 1'b1;
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b1);
        check("t7_no_words_after", 64'(got.size()), 64'd0);
        q.push_back(mk(4'h2, 28'd0, $urandom));
        q.push_back(mk(4'h2, 28'(NREGS - 1), $urandom));
        drain(1'b0, "t7");
        check("t7_reg0_cleared", got_at(0), 64'h2000_0000_0000_0000);
        compare_outputs("t7");

        check("fpc_read_protocol", 64'(viol), 64'd0);
        check("tpc_hold_protocol", 64'(hold_viol), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
